// File: rtl/stream_vector_source.sv
// rtl/stream_vector_source.sv - register-buffered vector replayed as one contiguous stream burst per start
module stream_vector_source #(
    parameter  int BITS   = 8,
    parameter  int LENGTH = 10,
    localparam int AW     = $clog2(LENGTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [BITS-1:0] wr_data,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            out_valid,
    output logic [BITS-1:0] a
);

    // The index must be able to hold LENGTH itself, which marks "last element already shown".
    localparam int            CW   = $clog2(LENGTH + 1);
    localparam logic [CW-1:0] LAST = CW'(LENGTH);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_index, w_index_nxt;
    logic            r_out_valid, w_out_valid_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_done, w_done_nxt;
    logic [BITS-1:0] r_a, w_a_nxt;
    logic [BITS-1:0] r_buf [LENGTH];

    logic            w_wr_ok;
    logic [BITS-1:0] w_rd_data;

    // An accepted start owns the edge, so a coincident write is dropped.
    assign w_wr_ok   = wr_en && (r_state == S_IDLE) && !start
                     && ({1'b0, wr_addr} < (AW + 1)'(LENGTH));
    assign w_rd_data = (r_index < LAST) ? r_buf[r_index[AW-1:0]] : '0;

    // Element buffer: written only while idle, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LENGTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_buf[wr_addr] <= wr_data;
        end
    end

    // Next state and next registered outputs; every output idles low and zero.
    always_comb begin
        w_state_nxt     = r_state;
        w_index_nxt     = r_index;
        w_out_valid_nxt = 1'b0;
        w_a_nxt         = '0;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt     = S_STREAM;
                    w_index_nxt     = CW'(1);
                    w_out_valid_nxt = 1'b1;
                    w_a_nxt         = r_buf[0];
                    w_busy_nxt      = 1'b1;
                end
            end
            S_STREAM: begin
                w_busy_nxt = 1'b1;
                if (r_index == LAST) begin
                    w_state_nxt = S_GAP;
                    w_index_nxt = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_out_valid_nxt = 1'b1;
                    w_a_nxt         = w_rd_data;
                    w_index_nxt     = r_index + CW'(1);
                end
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_index_nxt = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any burst without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_index     <= '0;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_index     <= w_index_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_a         <= w_a_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign a         = r_a;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
